io_bus_arbiter: RTL and testbench

//  Shares the single io-register access port (addr/data_in/data_out/read/write/width)

---
 rtl/io_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the io-register port between CPU (M0) and DMA (M1)
// round-robin arbitration with a bounded bus lock for bursts
module io_bus_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk_mem,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  input  logic [1:0]        m0_width,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
  input  logic [1:0]        m1_width,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_read,
  output logic              io_write,
  output logic [1:0]        io_width,
  input  logic [DATA_W-1:0] io_rdata
);

  localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK - 1);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e            state_q;
  logic              ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              own_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              cmd_write_q;
  logic [1:0]        cmd_width_q;
  logic              cmd_lock_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;
  logic [ADDR_W-1:0] io_addr_q;
  logic [DATA_W-1:0] io_wdata_q;
  logic              io_read_q;
  logic              io_write_q;
  logic [1:0]        io_width_q;
  logic              io_own_q;

  logic [1:0]        req;
  logic              win;
  logic              sel;
  logic              own_req;
  logic              oth_req;
  logic              lock_go;
  logic              take;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic [1:0]        sel_width;
  logic              sel_lock;

  // pick the next command source: arbitration winner or the lock holder
  always_comb begin
    req       = {m1_req, m0_req};
    win       = (&req) ? ptr_q : req[1];
    sel       = (state_q == ACCESS) ? own_q : win;
    own_req   = own_q ? m1_req : m0_req;
    oth_req   = own_q ? m0_req : m1_req;
    lock_go   = cmd_lock_q & own_req &
                (~oth_req | (cnt_q < CNT_MAX));
    take      = (state_q == ACCESS) ? lock_go : (|req);
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    sel_write = sel ? m1_write : m0_write;
    sel_width = sel ? m1_width : m0_width;
    sel_lock  = sel ? m1_lock  : m0_lock;
  end

  // arbitration FSM with registered grant, io strobe and completion
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      own_q       <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_write_q <= 1'b0;
      cmd_width_q <= '0;
      cmd_lock_q  <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      io_read_q   <= 1'b0;
      io_write_q  <= 1'b0;
      io_width_q  <= '0;
      io_own_q    <= 1'b0;
    end else begin
      gnt_q      <= '0;
      done_q     <= '0;
      io_read_q  <= 1'b0;
      io_write_q <= 1'b0;
      if (io_read_q | io_write_q) begin
        done_q[io_own_q] <= 1'b1;
        if (io_read_q) begin
          if (io_own_q) rd1_q <= io_rdata;
          else          rd0_q <= io_rdata;
        end
      end
      if (take) begin
        own_q       <= sel;
        cmd_addr_q  <= sel_addr;
        cmd_wdata_q <= sel_wdata;
        cmd_write_q <= sel_write;
        cmd_width_q <= sel_width;
        cmd_lock_q  <= sel_lock;
        gnt_q[sel]  <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (take) state_q <= ACCESS;
        end
        ACCESS: begin
          io_addr_q  <= cmd_addr_q;
          io_wdata_q <= cmd_wdata_q;
          io_width_q <= cmd_width_q;
          io_read_q  <= ~cmd_write_q;
          io_write_q <= cmd_write_q;
          io_own_q   <= own_q;
          if (lock_go) begin
            if (oth_req) cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q   <= '0;
            ptr_q   <= ~own_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt   = gnt_q[0];
  assign m1_gnt   = gnt_q[1];
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_rdata = rd0_q;
  assign m1_rdata = rd1_q;
  assign io_addr  = io_addr_q;
  assign io_wdata = io_wdata_q;
  assign io_read  = io_read_q;
  assign io_write = io_write_q;
  assign io_width = io_width_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level schedule model
module tb_io_bus_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int ML = 4;
  localparam int NE = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          m_req[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wdata[2];
  logic          m_write[2];
  logic [1:0]    m_width[2];
  logic          m_lock[2];
  logic [DW-1:0] io_rdata;

  logic          m0_gnt, m0_done, m1_gnt, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata;
  logic          io_read, io_write;
  logic [1:0]    io_width;

  always #5 clk = ~clk;

  io_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)
  ) dut (
    .clk_mem(clk), .rst_n(rst_n),
    .m0_req(m_req[0]), .m0_addr(m_addr[0]),
    .m0_wdata(m_wdata[0]), .m0_write(m_write[0]),
    .m0_width(m_width[0]), .m0_lock(m_lock[0]),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m0_rdata(m0_rdata),
    .m1_req(m_req[1]), .m1_addr(m_addr[1]),
    .m1_wdata(m_wdata[1]), .m1_write(m_write[1]),
    .m1_width(m_width[1]), .m1_lock(m_lock[1]),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .m1_rdata(m1_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_read(io_read), .io_write(io_write),
    .io_width(io_width), .io_rdata(io_rdata)
  );

  typedef struct packed {
    logic [1:0]    gnt;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    width;
    logic [1:0]    done;
    logic          cap;
    logic          cown;
  } ev_t;

  ev_t           ev[NE];
  int            e;
  int            checks;
  int            errors;
  bit            have_last;
  logic          lw;
  logic          last_lock;
  int            last_e;
  int            extra;
  logic [DW-1:0] rd_m[2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) ev[i] = '0;
    have_last = 1'b0;
    extra     = 0;
    rd_m[0]   = '0;
    rd_m[1]   = '0;
  endtask

  // schedule: grant at edge n, io strobe after n+1, done after n+2
  task automatic model_step();
    logic [1:0] r;
    logic       w;
    bit         g;
    e++;
    if (ev[e].cap) rd_m[ev[e].cown] = io_rdata;
    r = {m_req[1], m_req[0]};
    g = 1'b0;
    w = 1'b0;
    if (have_last && e == last_e + 1 && last_lock && r[lw] &&
        (!r[!lw] || extra < ML - 1)) begin
      w = lw;
      g = 1'b1;
      if (r[!lw]) extra++;
    end else if ((!have_last || e >= last_e + 2) && r != 2'b00) begin
      if (r == 2'b11) w = have_last ? !lw : 1'b0;
      else            w = r[1];
      g = 1'b1;
      extra = 0;
    end
    if (g) begin
      ev[e].gnt[w]     = 1'b1;
      ev[e+1].rd       = !m_write[w];
      ev[e+1].wr       = m_write[w];
      ev[e+1].addr     = m_addr[w];
      ev[e+1].wdata    = m_wdata[w];
      ev[e+1].width    = m_width[w];
      ev[e+2].done[w]  = 1'b1;
      if (!m_write[w]) begin
        ev[e+2].cap  = 1'b1;
        ev[e+2].cown = w;
      end
      have_last = 1'b1;
      last_e    = e;
      lw        = w;
      last_lock = m_lock[w];
    end
  endtask

  task automatic compare();
    ev_t x;
    x = ev[e];
    chk("gnt", {m1_gnt, m0_gnt}, x.gnt);
    chk("done", {m1_done, m0_done}, x.done);
    chk("strobe", {io_read, io_write}, {x.rd, x.wr});
    if (x.rd | x.wr)
      chk("io_cmd", {io_addr, io_wdata, io_width},
          {x.addr, x.wdata, x.width});
    chk("rdata0", m0_rdata, rd_m[0]);
    chk("rdata1", m1_rdata, rd_m[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_cmd(input int m);
    m_addr[m]  = AW'($urandom);
    m_wdata[m] = $urandom;
    m_write[m] = 1'($urandom_range(0, 1));
    m_width[m] = 2'($urandom_range(0, 3));
    m_lock[m]  = ($urandom_range(0, 2) == 0);
  endtask

  task automatic drive(input int m, input logic rq, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] wd, input logic lk);
    m_req[m]   = rq;
    m_write[m] = wr;
    m_addr[m]  = a;
    m_wdata[m] = d;
    m_width[m] = wd;
    m_lock[m]  = lk;
  endtask

  logic [15:0] hist;
  logic        acc;

  initial begin
    checks = 0;
    errors = 0;
    e      = -1;
    last_e = 0;
    lw = 1'b0;
    last_lock = 1'b0;
    io_rdata = '0;
    for (int m = 0; m < 2; m++) drive(m, 0, 0, '0, '0, 2'b00, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_outs", {m1_gnt, m0_gnt, m1_done, m0_done, io_read,
                     io_write, io_addr, io_width}, '0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, '0);
    rst_n = 1'b1;

    // single M0 read
    drive(0, 1, 0, 24'h000004, '0, 2'b10, 0);
    io_rdata = 32'h00A50012;
    tick();
    chk("t1_gnt", m0_gnt, 1'b1);
    m_req[0] = 1'b0;
    tick();
    chk("t1_io", {io_read, io_write, io_addr}, {2'b10, 24'h000004});
    tick();
    chk("t1_done", {m0_done, m0_rdata}, {1'b1, 32'h00A50012});
    tick();

    // single M1 byte write
    drive(1, 1, 1, 24'h000400, 32'h000001AB, 2'b00, 0);
    tick();
    chk("t4_gnt", m1_gnt, 1'b1);
    m_req[1] = 1'b0;
    tick();
    chk("t4_io", {io_write, io_read, io_wdata, io_width},
        {2'b10, 32'h000001AB, 2'b00});
    tick();
    chk("t4_done", {m1_done, m1_rdata}, {1'b1, 32'h0});
    tick();

    // M0 locked burst while M1 waits
    drive(0, 1, 0, 24'h000010, '0, 2'b10, 1);
    drive(1, 1, 1, 24'h000020, 32'h55, 2'b10, 0);
    hist = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hist = {hist[13:0], m1_gnt, m0_gnt};
    end
    chk("t3_order", hist[11:0], 12'b01_01_01_01_00_10);
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
    repeat (3) tick();

    // both requesting, no lock: alternate
    drive(0, 1, 1, 24'h000030, 32'h11, 2'b01, 0);
    drive(1, 1, 0, 24'h000040, '0, 2'b10, 0);
    hist = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      hist = {hist[13:0], m1_gnt, m0_gnt};
    end
    chk("t2_order", hist, 16'b01_00_10_00_01_00_10_00);
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
    repeat (3) tick();

    // M0 pulses req while M1 is mid-access
    drive(1, 1, 0, 24'h000050, '0, 2'b10, 0);
    tick();
    chk("t6_gnt", m1_gnt, 1'b1);
    m_req[1] = 1'b0;
    m_req[0] = 1'b1;
    acc = 1'b0;
    tick();
    acc = acc | m0_gnt | m0_done;
    m_req[0] = 1'b0;
    tick();
    acc = acc | m0_gnt | m0_done;
    tick();
    acc = acc | m0_gnt | m0_done;
    chk("t6_idle_a", {io_read, io_write}, 2'b00);
    tick();
    acc = acc | m0_gnt | m0_done;
    chk("t6_idle_b", {io_read, io_write}, 2'b00);
    chk("t6_m0", acc, 1'b0);

    // reset during the io cycle of an M1 write
    drive(1, 1, 1, 24'h000060, 32'hCAFE, 2'b10, 0);
    tick();
    m_req[1] = 1'b0;
    tick();
    chk("t5_strobe", io_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_drop", {io_write, io_read}, 2'b00);
    model_reset();
    tick();
    chk("t5_nodone", m1_done, 1'b0);
    rst_n = 1'b1;
    drive(0, 1, 0, 24'h000070, '0, 2'b10, 0);
    drive(1, 1, 0, 24'h000080, '0, 2'b10, 0);
    tick();
    chk("t5_first", {m1_gnt, m0_gnt}, 2'b01);
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
    repeat (3) tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      io_rdata = $urandom;
      for (int m = 0; m < 2; m++) begin
        if (m_req[m] && ev[e].gnt[m]) begin
          if ($urandom_range(0, 1) == 1) set_cmd(m);
          else m_req[m] = 1'b0;
        end else if (m_req[m]) begin
          if ($urandom_range(0, 15) == 0) m_req[m] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_req[m] = 1'b1;
          set_cmd(m);
        end
      end
    end
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
